// File: rtl/axil_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// axil_arbiter_2x1
// Two-master to one-slave AXI-Lite arbiter. Read and write channels are
// arbitrated independently with one outstanding transaction per channel.
// A grant is held from address acceptance until the response handshake.
//
// Build option:
//   AXIL_ARB_RR_EN  defined   -> round-robin priority per channel
//                   undefined -> fixed priority, s0 wins simultaneous requests
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   s0_* / s1_*          upstream AXI-Lite slave ports (aw, w, b, ar, r)
//   m_*                  downstream AXI-Lite master port (aw, w, b, ar, r)
// ---------------------------------------------------------------------------
module axil_arbiter_2x1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0
    input  logic [ADDR_WIDTH-1:0] s0_awaddr,
    input  logic [2:0]            s0_awprot,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    input  logic [STRB_WIDTH-1:0] s0_wstrb,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    output logic [1:0]            s0_bresp,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [2:0]            s0_arprot,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    // master 1
    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic [2:0]            s1_awprot,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    input  logic [STRB_WIDTH-1:0] s1_wstrb,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    output logic [1:0]            s1_bresp,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [2:0]            s1_arprot,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    // downstream slave
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP
    } state_t;

    // ---------------- write channel state ----------------
    state_t r_wstate, w_wstate_nxt;
    logic   r_wgrant;          // 0 = s0, 1 = s1
    logic   r_aw_done;
    logic   r_w_done;
    logic   w_wpick;
    logic   w_aw_hs, w_w_hs, w_b_hs;

    // ---------------- read channel state -----------------
    state_t r_rstate, w_rstate_nxt;
    logic   r_rgrant;
    logic   w_rpick;
    logic   w_ar_hs, w_r_hs;

    // Selected (granted) master's request/response-ready signals
    logic w_sel_awvalid, w_sel_wvalid, w_sel_bready;
    logic w_sel_arvalid, w_sel_rready;

    assign w_sel_awvalid = r_wgrant ? s1_awvalid : s0_awvalid;
    assign w_sel_wvalid  = r_wgrant ? s1_wvalid  : s0_wvalid;
    assign w_sel_bready  = r_wgrant ? s1_bready  : s0_bready;
    assign w_sel_arvalid = r_rgrant ? s1_arvalid : s0_arvalid;
    assign w_sel_rready  = r_rgrant ? s1_rready  : s0_rready;

    // Payload passes through untouched; valid qualifies it.
    assign m_awaddr = r_wgrant ? s1_awaddr : s0_awaddr;
    assign m_awprot = r_wgrant ? s1_awprot : s0_awprot;
    assign m_wdata  = r_wgrant ? s1_wdata  : s0_wdata;
    assign m_wstrb  = r_wgrant ? s1_wstrb  : s0_wstrb;
    assign m_araddr = r_rgrant ? s1_araddr : s0_araddr;
    assign m_arprot = r_rgrant ? s1_arprot : s0_arprot;

    assign s0_bresp = m_bresp;
    assign s1_bresp = m_bresp;
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;

    // ---------------- arbitration ----------------
`ifdef AXIL_ARB_RR_EN
    logic r_wprio;  // master favoured on a tie
    logic r_rprio;

    assign w_wpick = (s0_awvalid && s1_awvalid) ? r_wprio : !s0_awvalid;
    assign w_rpick = (s0_arvalid && s1_arvalid) ? r_rprio : !s0_arvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wprio <= 1'b0;
            r_rprio <= 1'b0;
        end else begin
            if (w_b_hs) r_wprio <= !r_wgrant;
            if (w_r_hs) r_rprio <= !r_rgrant;
        end
    end
`else
    assign w_wpick = !s0_awvalid;
    assign w_rpick = !s0_arvalid;
`endif

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= ST_IDLE;
            r_wgrant  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            case (r_wstate)
                ST_IDLE: if (s0_awvalid || s1_awvalid) r_wgrant <= w_wpick;
                ST_ADDR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                ST_RESP: if (w_b_hs) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        m_awvalid    = 1'b0;
        m_wvalid     = 1'b0;
        m_bready     = 1'b0;
        s0_awready   = 1'b0;
        s1_awready   = 1'b0;
        s0_wready    = 1'b0;
        s1_wready    = 1'b0;
        s0_bvalid    = 1'b0;
        s1_bvalid    = 1'b0;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        w_b_hs       = 1'b0;
        case (r_wstate)
            ST_IDLE: if (s0_awvalid || s1_awvalid) w_wstate_nxt = ST_ADDR;
            ST_ADDR: begin
                // A completed sub-channel stops driving valid while the other finishes.
                m_awvalid  = w_sel_awvalid && !r_aw_done;
                m_wvalid   = w_sel_wvalid  && !r_w_done;
                s0_awready = !r_wgrant && !r_aw_done && m_awready;
                s1_awready =  r_wgrant && !r_aw_done && m_awready;
                s0_wready  = !r_wgrant && !r_w_done  && m_wready;
                s1_wready  =  r_wgrant && !r_w_done  && m_wready;
                w_aw_hs    = m_awvalid && m_awready;
                w_w_hs     = m_wvalid  && m_wready;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_wstate_nxt = ST_RESP;
            end
            ST_RESP: begin
                m_bready  = w_sel_bready;
                s0_bvalid = !r_wgrant && m_bvalid;
                s1_bvalid =  r_wgrant && m_bvalid;
                w_b_hs    = m_bvalid && m_bready;
                if (w_b_hs) w_wstate_nxt = ST_IDLE;
            end
            default: w_wstate_nxt = ST_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= ST_IDLE;
            r_rgrant <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (r_rstate == ST_IDLE && (s0_arvalid || s1_arvalid))
                r_rgrant <= w_rpick;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        s0_arready   = 1'b0;
        s1_arready   = 1'b0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        w_ar_hs      = 1'b0;
        w_r_hs       = 1'b0;
        case (r_rstate)
            ST_IDLE: if (s0_arvalid || s1_arvalid) w_rstate_nxt = ST_ADDR;
            ST_ADDR: begin
                m_arvalid  = w_sel_arvalid;
                s0_arready = !r_rgrant && m_arready;
                s1_arready =  r_rgrant && m_arready;
                w_ar_hs    = m_arvalid && m_arready;
                if (w_ar_hs) w_rstate_nxt = ST_RESP;
            end
            ST_RESP: begin
                m_rready  = w_sel_rready;
                s0_rvalid = !r_rgrant && m_rvalid;
                s1_rvalid =  r_rgrant && m_rvalid;
                w_r_hs    = m_rvalid && m_rready;
                if (w_r_hs) w_rstate_nxt = ST_IDLE;
            end
            default: w_rstate_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/axil_arbiter_2x1.md
# axil_arbiter_2x1

Two-master to one-slave AXI-Lite arbiter placed between two bus masters (CPU core via its aligner, and a second master such as a DMA or debug loader) and the crossbar slave port. Read and write channels are arbitrated independently, one outstanding transaction per channel. Each grant is held from address acceptance until the response handshake completes, then released.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- s0_awaddr/s1_awaddr, s0_awprot/s1_awprot, s0_awvalid/s1_awvalid  in  ADDR_WIDTH/3/1  requester write address
- s0_awready/s1_awready  out  1  write address accept
- s0_wdata/s1_wdata, s0_wstrb/s1_wstrb, s0_wvalid/s1_wvalid  in  DATA_WIDTH/STRB_WIDTH/1  requester write data
- s0_wready/s1_wready  out  1  write data accept
- s0_bresp/s1_bresp, s0_bvalid/s1_bvalid  out  2/1  write response; s0_bready/s1_bready in 1
- s0_araddr/s1_araddr, s0_arprot/s1_arprot, s0_arvalid/s1_arvalid  in  ADDR_WIDTH/3/1  read address; s0_arready/s1_arready out 1
- s0_rdata/s1_rdata, s0_rresp/s1_rresp, s0_rvalid/s1_rvalid  out  DATA_WIDTH/2/1  read data; s0_rready/s1_rready in 1
- m_awaddr, m_awprot, m_awvalid  out  ADDR_WIDTH/3/1  downstream write address; m_awready in 1
- m_wdata, m_wstrb, m_wvalid  out  DATA_WIDTH/STRB_WIDTH/1  downstream write data; m_wready in 1
- m_bresp, m_bvalid  in  2/1  downstream write response; m_bready out 1
- m_araddr, m_arprot, m_arvalid  out  ADDR_WIDTH/3/1  downstream read address; m_arready in 1
- m_rdata, m_rresp, m_rvalid  in  DATA_WIDTH/2/1  downstream read data; m_rready out 1

## Operation
- Write FSM: IDLE -> ADDR -> RESP -> IDLE. Read FSM: IDLE -> ADDR -> RESP -> IDLE. The two FSMs are independent; a read to one master and a write to the other proceed concurrently.
- IDLE: a write request is sN_awvalid=1; a read request is sN_arvalid=1. The winner is latched into wgrant/rgrant, and the FSM moves to ADDR.
- Write ADDR: granted sN_aw*/w* are forwarded to m_; m_awready/m_wready are routed back to the granted master only. aw_done and w_done flags latch each handshake, and a channel whose flag is set forces its m_*valid=0. When both flags are set, the FSM goes to RESP.
- Write RESP: m_b* is routed to the granted master and m_bready=sN_bready. On m_bvalid&&m_bready the FSM returns to IDLE, the flags clear and the priority updates.
- Read ADDR: forward ar. On m_arvalid&&m_arready go to RESP. Read RESP: route r. On m_rvalid&&m_rready go to IDLE.
- The non-granted master always sees awready/wready/arready/bvalid/rvalid=0. Its data outputs mirror m_ data, but valid is 0.
- Arbitration priority is set by RR_EN (see Configuration).
- The arbiter never modifies address, data, strobe, prot or resp.

## Timing
- Reset (rst=0, async): both FSMs go to IDLE, flags clear, and the priority pointers point to s0. All m_*valid, m_bready, m_rready and all s*_ready/valid outputs are 0. Any in-flight transaction is dropped.
- Grant latency: request seen in IDLE at cycle n -> m_awvalid/m_arvalid=1 at cycle n+1.
- Return to IDLE: the cycle after the response handshake. A new request at that point is granted the following cycle, so the minimum write or read period is 3 cycles with a zero-wait slave.
- Valid/data on m_ stay stable while the FSM is in ADDR (AXI rule).
- aw and w may complete in either order or in the same cycle.
- A deasserted request in IDLE is not latched, and there is no speculative grant.

## Configuration
- AXIL_ARB_RR_EN defined: round-robin. After each completed transaction, that channel's priority pointer moves to the other master. A simultaneous request goes to the pointer's master.
- AXIL_ARB_RR_EN undefined: fixed priority, s0 always wins a simultaneous request, and the pointer logic is not compiled.

## Test plan
- Single write: s0 writes 0x10000004 / 0xDEADBEEF / wstrb 0xF with a zero-wait slave. m_awvalid and m_wvalid rise 1 cycle after the request. s0_bvalid=1, bresp=0. s1 ready/valid stay 0 throughout.
- Simultaneous reads: s0 and s1 both request in the same cycle, and then both keep requesting.
  - RR_EN: grants alternate s0, s1, s0.
  - Without RR_EN: s0 is granted three times in a row and s1 waits.
- Split write: m_awready arrives 2 cycles before m_wready. m_awvalid drops after its handshake, and RESP is entered only after the w handshake.
- Concurrent channels: s0 write and s1 read issued in the same cycle. Both complete, each with 3-cycle latency, and neither stalls the other.
- Backpressure: s1_rready is held 0 for 5 cycles. m_rready=0 and s1 rdata stays stable; on release it completes and the FSM returns to IDLE.
- Reset mid-op: rst=0 during write RESP. All outputs are 0 immediately (async). After release, the next request is granted to s0.
